dht22_reader: RTL

- Single-wire humidity/temperature sensor front end (DHT22 protocol).
- Sits directly upstream of the SPI slave and produces the 40-bit HYM2 vector that the slave snapshots at the start of each SPI message.
- Issues the start pulse, decodes the 40 data bits by high-pulse width and validates the checksum.
- Updates HYM2 only with verified frames, so the SPI side never sees a partial or corrupt frame.

---
 rtl/dht22_reader.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dht22_reader.sv
// dht22_reader: DHT22 single-wire sensor front end. Issues the host start
// pulse, times the sensor's high pulses to decode 40 bits MSB first, checks
// the checksum and publishes HYM2 only for verified frames.
module dht22_reader #(
  parameter int unsigned CLK_FREQ_HZ    = 50000000,
  parameter int unsigned START_LOW_US   = 1000,
  parameter int unsigned BIT_THRESH_US  = 40,
  parameter int unsigned TIMEOUT_US     = 200,
  parameter int unsigned POLL_PERIOD_MS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_drive_low,
  output logic [39:0] HYM2,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned DIV       = (CLK_FREQ_HZ / 1000000 > 0) ? CLK_FREQ_HZ / 1000000 : 1;
  localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PHASE_W   = 16;
  localparam int unsigned MS_W      = 10;
  localparam int unsigned POLL_W    = 16;
  localparam int unsigned FRAME_W   = 40;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned POLL_LAST = (POLL_PERIOD_MS > 0) ? POLL_PERIOD_MS - 1 : 0;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START_LOW = 4'd1;
  localparam logic [3:0] S_WAIT_RESP = 4'd2;
  localparam logic [3:0] S_RESP_LOW  = 4'd3;
  localparam logic [3:0] S_RESP_HIGH = 4'd4;
  localparam logic [3:0] S_BIT_LOW   = 4'd5;
  localparam logic [3:0] S_BIT_HIGH  = 4'd6;
  localparam logic [3:0] S_CHECK     = 4'd7;
  localparam logic [3:0] S_ERROR     = 4'd8;

  logic [3:0]         state;
  logic [3:0]         next_state;

  logic               sync1;
  logic               sync2;
  logic               line_q;
  logic               rise_c;
  logic               fall_c;

  logic [DIV_W-1:0]   us_div;
  logic               us_tick_c;
  logic [MS_W-1:0]    ms_us;
  logic               ms_tick_c;
  logic [POLL_W-1:0]  poll_cnt;
  logic               poll_fire_c;
  logic               trigger_c;

  logic [DIV_W-1:0]   phase_div;
  logic               phase_tick_c;
  logic [PHASE_W-1:0] phase_us;
  logic [PHASE_W-1:0] phase_now_c;
  logic               phase_clr_c;
  logic               phase_timeout_c;

  logic [FRAME_W-1:0] shift_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [7:0]         sum_c;
  logic               sum_ok_c;
  logic               bit_c;
  logic               timeout_c;

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= dht_in;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  assign rise_c = sync2 & ~line_q;
  assign fall_c = ~sync2 & line_q;

  // Free-running microsecond tick feeding the poll timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_div <= '0;
    end else if (us_tick_c) begin
      us_div <= '0;
    end else begin
      us_div <= us_div + DIV_W'(1);
    end
  end

  assign us_tick_c = (us_div == DIV_W'(DIV - 1));
  assign ms_tick_c = us_tick_c && (ms_us == MS_W'(999));

  // Millisecond poll timer; reloads on every expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_us    <= '0;
      poll_cnt <= '0;
    end else begin
      if (us_tick_c) begin
        ms_us <= ms_tick_c ? '0 : ms_us + MS_W'(1);
      end
      if (ms_tick_c) begin
        poll_cnt <= poll_fire_c ? '0 : poll_cnt + POLL_W'(1);
      end
    end
  end

  assign poll_fire_c = (POLL_PERIOD_MS != 0) && ms_tick_c && (poll_cnt == POLL_W'(POLL_LAST));
  assign trigger_c   = start | poll_fire_c;

  // Phase timer restarts its own divider on every state change so that
  // phase durations are exact multiples of one microsecond.
  assign phase_tick_c    = (phase_div == DIV_W'(DIV - 1));
  assign phase_now_c     = (phase_tick_c && (phase_us != '1)) ? phase_us + PHASE_W'(1) : phase_us;
  assign phase_timeout_c = (phase_now_c >= PHASE_W'(TIMEOUT_US));
  assign phase_clr_c     = (next_state != state) || ((state == S_ERROR) && !sync2);

  // Phase microsecond counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_div <= '0;
      phase_us  <= '0;
    end else if (phase_clr_c) begin
      phase_div <= '0;
      phase_us  <= '0;
    end else begin
      phase_div <= phase_tick_c ? '0 : phase_div + DIV_W'(1);
      phase_us  <= phase_now_c;
    end
  end

  assign bit_c    = (phase_now_c > PHASE_W'(BIT_THRESH_US));
  assign sum_c    = shift_reg[39:32] + shift_reg[31:24] + shift_reg[23:16] + shift_reg[15:8];
  assign sum_ok_c = (sum_c == shift_reg[7:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a bus edge wins over a coincident timeout
  always_comb begin
    next_state = state;
    timeout_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger_c) next_state = S_START_LOW;
      end
      S_START_LOW: begin
        if (phase_now_c >= PHASE_W'(START_LOW_US)) next_state = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (fall_c) begin
          next_state = S_RESP_LOW;
        end else if (phase_timeout_c) begin
          next_state = S_ERROR;
          timeout_c  = 1'b1;
        end
      end
      S_RESP_LOW: begin
        if (rise_c) begin
          next_state = S_RESP_HIGH;
        end else if (phase_timeout_c) begin
          next_state = S_ERROR;
          timeout_c  = 1'b1;
        end
      end
      S_RESP_HIGH: begin
        if (fall_c) begin
          next_state = S_BIT_LOW;
        end else if (phase_timeout_c) begin
          next_state = S_ERROR;
          timeout_c  = 1'b1;
        end
      end
      S_BIT_LOW: begin
        if (rise_c) begin
          next_state = S_BIT_HIGH;
        end else if (phase_timeout_c) begin
          next_state = S_ERROR;
          timeout_c  = 1'b1;
        end
      end
      S_BIT_HIGH: begin
        if (fall_c) begin
          next_state = (bit_cnt == CNT_W'(FRAME_W - 1)) ? S_CHECK : S_BIT_LOW;
        end else if (phase_timeout_c) begin
          next_state = S_ERROR;
          timeout_c  = 1'b1;
        end
      end
      S_CHECK: begin
        next_state = S_IDLE;
      end
      S_ERROR: begin
        if (sync2 && phase_timeout_c) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Registered outputs, shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dht_drive_low <= 1'b0;
      busy          <= 1'b0;
      frame_valid   <= 1'b0;
      crc_err       <= 1'b0;
      timeout_err   <= 1'b0;
      HYM2          <= '0;
      shift_reg     <= '0;
      bit_cnt       <= '0;
    end else begin
      dht_drive_low <= (next_state == S_START_LOW);
      busy          <= (next_state != S_IDLE);
      frame_valid   <= 1'b0;

      if ((state == S_IDLE) && (next_state == S_START_LOW)) begin
        crc_err     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (timeout_c) begin
        timeout_err <= 1'b1;
      end

      if ((next_state == S_WAIT_RESP) && (state != S_WAIT_RESP)) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if ((state == S_BIT_HIGH) && fall_c) begin
        shift_reg <= {shift_reg[FRAME_W-2:0], bit_c};
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end

      if (state == S_CHECK) begin
        if (sum_ok_c) begin
          HYM2        <= shift_reg;
          frame_valid <= 1'b1;
        end else begin
          crc_err <= 1'b1;
        end
      end
    end
  end

endmodule
